// File: rtl/contador_ad_bcd_param_pkg.sv
// Shared types and constants for the BCD field counters.
// Button FSM encoding, field-select codes, default prescaler.
package contador_ad_bcd_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } btn_state_t;

    localparam logic [3:0] FIELD_SEG  = 4'd1;
    localparam logic [3:0] FIELD_MIN  = 4'd2;
    localparam logic [3:0] FIELD_HORA = 4'd3;
    localparam logic [3:0] FIELD_DIA  = 4'd4;
    localparam logic [3:0] FIELD_MES  = 4'd5;
    localparam logic [3:0] FIELD_ANO  = 4'd6;

    localparam int DIV_DEFAULT = 12999999;

endpackage

// File: rtl/contador_ad_bcd_param_if.sv
// Control/chain/display bundle of one time-field counter.
// master drives requests, slave is the counter.
interface contador_ad_bcd_param_if #(
    parameter int N = 5
);
    logic         enUP;
    logic         enDOWN;
    logic [3:0]   en_count;
    logic         formato_hora;
    logic         inc_in;
    logic         dec_in;
    logic         load;
    logic [N-1:0] load_val;
    logic         carry_out;
    logic         borrow_out;
    logic [N-1:0] count;
    logic         AM_PM;
    logic [3:0]   digit1;
    logic [3:0]   digit0;

    modport master (
        output enUP, enDOWN, en_count, formato_hora,
        output inc_in, dec_in, load, load_val,
        input  carry_out, borrow_out, count,
        input  AM_PM, digit1, digit0
    );

    modport slave (
        input  enUP, enDOWN, en_count, formato_hora,
        input  inc_in, dec_in, load, load_val,
        output carry_out, borrow_out, count,
        output AM_PM, digit1, digit0
    );
endinterface

// File: rtl/contador_ad_bcd_param_bin2bcd_hora.sv
// Binary to 2-digit BCD with optional 12 h / AM-PM mapping.
// Purely combinational; values above 99 show as 9,9.
module bin2bcd_hora #(
    parameter int N         = 5,
    parameter int HOUR_MODE = 1,
    parameter int MAXV      = 23
) (
    input  logic [N-1:0] bin,
    input  logic         formato_hora,
    output logic [3:0]   digit1,
    output logic [3:0]   digit0,
    output logic         AM_PM
);
    localparam int W = (N > 7) ? N : 7;
    localparam bit HOURS = (HOUR_MODE == 1) && (MAXV == 23);

    logic [W-1:0] b;
    logic [6:0]   v;

    assign b = W'(bin);

    always_comb begin
        v     = 7'd0;
        AM_PM = 1'b0;
        if (b > W'(99)) begin
            v = 7'd99;
        end else if (HOURS && formato_hora) begin
            if (b == '0) begin
                v = 7'd12;
            end else if (b < W'(12)) begin
                v = 7'(b);
            end else if (b == W'(12)) begin
                v     = 7'd12;
                AM_PM = 1'b1;
            end else begin
                v     = 7'(b - W'(12));
                AM_PM = 1'b1;
            end
        end else begin
            v = 7'(b);
        end
        digit1 = 4'(v / 7'd10);
        digit0 = 4'(v % 7'd10);
    end
endmodule

// File: rtl/contador_ad_bcd_param.sv
// Up/down modulo counter for one time field with BCD display,
// button auto-repeat and carry/borrow chaining.
module contador_ad_bcd_param
    import contador_ad_bcd_param_pkg::*;
#(
    parameter int N          = 5,
    parameter int MINV       = 0,
    parameter int MAXV       = 23,
    parameter int FIELD_ID   = 3,
    parameter int HOUR_MODE  = 1,
    parameter int DIV        = DIV_DEFAULT,
    parameter int HOLD_TICKS = 2
) (
    input logic clk,
    input logic reset,
    contador_ad_bcd_param_if.slave bus
);
    localparam int PW = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [N-1:0] MIN_N = N'(MINV);
    localparam logic [N-1:0] MAX_N = N'(MAXV);

    logic [PW-1:0] pre_q;
    logic          tick;
    btn_state_t    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          dir_q, dir_d;
    logic          sel, one_up, one_dn, same;
    logic          step_up, step_dn;
    logic [N-1:0]  count_q, count_d;
    logic          carry_d, borrow_d;
    logic          at_max, at_min, cnt_ok, ld_ok;
    logic [N-1:0]  up_val, dn_val;
    logic [N:0]    c_lo, c_hi, l_lo, l_hi;

    assign tick = (pre_q == PW'(DIV));

    always_ff @(posedge clk) begin
        if (!reset) pre_q <= '0;
        else        pre_q <= tick ? '0 : pre_q + 1'b1;
    end

    assign sel    = (bus.en_count == 4'(FIELD_ID));
    assign one_up = bus.enUP & ~bus.enDOWN;
    assign one_dn = bus.enDOWN & ~bus.enUP;
    // Held direction must persist; release, both or reversal all drop out.
    assign same   = dir_q ? one_up : one_dn;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        dir_d   = dir_q;
        if (!sel) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (one_up | one_dn) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                        dir_d   = one_up;
                    end
                end
                ST_HOLD: begin
                    if (!same) begin
                        state_d = ST_IDLE;
                    end else if (tick) begin
                        if (hold_q == HW'(HOLD_TICKS)) state_d = ST_REPEAT;
                        else                           hold_d  = hold_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!same) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        if (sel) begin
            if (state_q == ST_IDLE) begin
                step_up = one_up;
                step_dn = one_dn;
            end else if (state_q == ST_REPEAT && same && tick) begin
                step_up = dir_q;
                step_dn = ~dir_q;
            end
        end
    end

    // Range checks via sign of widened differences.
    assign c_lo   = {1'b0, count_q} - {1'b0, MIN_N};
    assign c_hi   = {1'b0, MAX_N} - {1'b0, count_q};
    assign l_lo   = {1'b0, bus.load_val} - {1'b0, MIN_N};
    assign l_hi   = {1'b0, MAX_N} - {1'b0, bus.load_val};
    assign cnt_ok = ~c_lo[N] & ~c_hi[N];
    assign ld_ok  = ~l_lo[N] & ~l_hi[N];
    assign at_max = (count_q == MAX_N);
    assign at_min = (count_q == MIN_N);
    assign up_val = at_max ? MIN_N : count_q + 1'b1;
    assign dn_val = at_min ? MAX_N : count_q - 1'b1;

    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (!cnt_ok) begin
            count_d = MIN_N;
        end else if (bus.load) begin
            count_d = ld_ok ? bus.load_val : MIN_N;
        end else if (step_up) begin
            count_d = up_val;
        end else if (step_dn) begin
            count_d = dn_val;
        end else if (bus.inc_in && !bus.dec_in) begin
            count_d = up_val;
            carry_d = at_max;
        end else if (bus.dec_in && !bus.inc_in) begin
            count_d  = dn_val;
            borrow_d = at_min;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q        <= MIN_N;
            bus.carry_out  <= 1'b0;
            bus.borrow_out <= 1'b0;
        end else begin
            count_q        <= count_d;
            bus.carry_out  <= carry_d;
            bus.borrow_out <= borrow_d;
        end
    end

    assign bus.count = count_q;

    bin2bcd_hora #(
        .N         (N),
        .HOUR_MODE (HOUR_MODE),
        .MAXV      (MAXV)
    ) u_bcd (
        .bin          (count_q),
        .formato_hora (bus.formato_hora),
        .digit1       (bus.digit1),
        .digit0       (bus.digit0),
        .AM_PM        (bus.AM_PM)
    );
endmodule

// File: tb/tb_contador_ad_bcd_param.sv
// Randomised and directed bench for the hour-field counter,
// checked against an arithmetic model of the field.
module tb_contador_ad_bcd_param;
    localparam int N    = 5;
    localparam int MINV = 0;
    localparam int MAXV = 23;
    localparam int FID  = 3;
    localparam int DIV  = 3;
    localparam int HT   = 2;
    localparam int RNG  = MAXV - MINV + 1;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    int m_count;
    bit m_carry, m_borrow;
    int m_dir;
    int m_ticks;
    int m_k;

    logic [3:0] e1, e0;
    logic       ep;

    contador_ad_bcd_param_if #(.N(N)) dif();

    contador_ad_bcd_param #(
        .N(N), .MINV(MINV), .MAXV(MAXV), .FIELD_ID(FID),
        .HOUR_MODE(1), .DIV(DIV), .HOLD_TICKS(HT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void exp_dec(input int c, input bit fh,
                                    output logic [3:0] d1,
                                    output logic [3:0] d0,
                                    output logic pm);
        int v;
        v  = c;
        pm = 1'b0;
        if (fh) begin
            pm = (c >= 12);
            v  = c % 12;
            if (v == 0) v = 12;
        end
        if (v > 99) v = 99;
        d1 = 4'(v / 10);
        d0 = 4'(v % 10);
    endfunction

    // Advance the model by the rules for the inputs now applied, then clock.
    task automatic step();
        int  d;
        int  st;
        bit  tk;
        int  lv;
        if (!reset) begin
            m_count  = MINV;
            m_carry  = 0;
            m_borrow = 0;
            m_dir    = 0;
            m_ticks  = 0;
            m_k      = 0;
        end else begin
            tk = ((m_k % (DIV + 1)) == DIV);
            m_k++;
            d  = (dif.enUP && !dif.enDOWN) ? 1 :
                 (dif.enDOWN && !dif.enUP) ? -1 : 0;
            st = 0;
            if (dif.en_count != 4'(FID)) begin
                m_dir = 0;
            end else if (m_dir == 0) begin
                if (d != 0) begin
                    st = d;
                    m_dir = d;
                    m_ticks = 0;
                end
            end else if (d != m_dir) begin
                m_dir = 0;
            end else if (tk) begin
                m_ticks++;
                if (m_ticks >= HT + 2) st = m_dir;
            end
            m_carry  = 0;
            m_borrow = 0;
            lv = int'(dif.load_val);
            if (dif.load) begin
                m_count = (lv >= MINV && lv <= MAXV) ? lv : MINV;
            end else if (st != 0) begin
                m_count = MINV + ((m_count - MINV + st + RNG) % RNG);
            end else if (dif.inc_in && !dif.dec_in) begin
                m_carry = (m_count == MAXV);
                m_count = MINV + ((m_count - MINV + 1) % RNG);
            end else if (dif.dec_in && !dif.inc_in) begin
                m_borrow = (m_count == MINV);
                m_count  = MINV + ((m_count - MINV - 1 + RNG) % RNG);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dif.enUP     = 0;
        dif.enDOWN   = 0;
        dif.en_count = 4'(FID);
        dif.inc_in   = 0;
        dif.dec_in   = 0;
        dif.load     = 0;
        dif.load_val = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        dif.formato_hora = 0;
        reset = 0;
        step();
        step();
        vectors++;
        if (dif.count !== 5'd0 || dif.digit1 !== 4'd0 ||
            dif.digit0 !== 4'd0 || dif.AM_PM !== 1'b0 ||
            dif.carry_out !== 1'b0 || dif.borrow_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: cnt=%0d d=%0d%0d pm=%b c=%b b=%b want 0 00 0 0 0",
                     dif.count, dif.digit1, dif.digit0, dif.AM_PM,
                     dif.carry_out, dif.borrow_out);
        end
        reset = 1;
        repeat (5) begin
            step();
            exp_dec(m_count, dif.formato_hora, e1, e0, ep);
            vectors++;
            if (dif.count !== 5'(m_count) || dif.digit1 !== e1 ||
                dif.digit0 !== e0 || dif.carry_out !== m_carry) begin
                miscompares++;
                $display("FAIL reset_idle: cnt=%0d d=%0d%0d c=%b want %0d %0d%0d %b",
                         dif.count, dif.digit1, dif.digit0, dif.carry_out,
                         m_count, e1, e0, m_carry);
            end
        end
    endtask

    task automatic test_edit_wrap();
        dif.load = 1;
        dif.load_val = 5'd23;
        step();
        dif.load = 0;
        dif.enUP = 1;
        step();
        vectors++;
        if (dif.count !== 5'd0 || dif.carry_out !== 1'b0 ||
            dif.count !== 5'(m_count)) begin
            miscompares++;
            $display("FAIL edit_wrap: cnt=%0d c=%b want 0 0 (model %0d)",
                     dif.count, dif.carry_out, m_count);
        end
        dif.enUP = 0;
        dif.formato_hora = 1;
        step();
        vectors++;
        if (dif.digit1 !== 4'd1 || dif.digit0 !== 4'd2 ||
            dif.AM_PM !== 1'b0 || dif.carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL edit_wrap_12h: d=%0d%0d pm=%b c=%b want 12 0 0",
                     dif.digit1, dif.digit0, dif.AM_PM, dif.carry_out);
        end
    endtask

    task automatic test_hold_repeat();
        int steps;
        int prev;
        dif.load = 1;
        dif.load_val = 5'd5;
        step();
        dif.load = 0;
        dif.enDOWN = 1;
        steps = 0;
        prev = 5;
        repeat (30) begin
            step();
            if (m_count != prev) steps++;
            prev = m_count;
            exp_dec(m_count, dif.formato_hora, e1, e0, ep);
            vectors++;
            if (dif.count !== 5'(m_count) || dif.digit1 !== e1 ||
                dif.digit0 !== e0 || dif.AM_PM !== ep ||
                dif.borrow_out !== 1'b0) begin
                miscompares++;
                $display("FAIL hold: cnt=%0d d=%0d%0d pm=%b b=%b want %0d %0d%0d %b 0",
                         dif.count, dif.digit1, dif.digit0, dif.AM_PM,
                         dif.borrow_out, m_count, e1, e0, ep);
            end
        end
        dif.enDOWN = 0;
        step();
        vectors++;
        if (dif.count !== 5'(m_count) || steps < 3) begin
            miscompares++;
            $display("FAIL hold_release: cnt=%0d steps=%0d want %0d >=3",
                     dif.count, steps, m_count);
        end
    endtask

    task automatic test_chain();
        dif.load = 1;
        dif.load_val = 5'd23;
        step();
        dif.load = 0;
        dif.inc_in = 1;
        step();
        dif.inc_in = 0;
        vectors++;
        if (dif.count !== 5'd0 || dif.carry_out !== 1'b1 ||
            dif.borrow_out !== 1'b0) begin
            miscompares++;
            $display("FAIL chain_carry: cnt=%0d c=%b b=%b want 0 1 0",
                     dif.count, dif.carry_out, dif.borrow_out);
        end
        step();
        vectors++;
        if (dif.carry_out !== 1'b0 || dif.count !== 5'd0) begin
            miscompares++;
            $display("FAIL chain_carry_end: cnt=%0d c=%b want 0 0",
                     dif.count, dif.carry_out);
        end
        dif.dec_in = 1;
        step();
        dif.dec_in = 0;
        vectors++;
        if (dif.count !== 5'd23 || dif.borrow_out !== 1'b1 ||
            dif.carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL chain_borrow: cnt=%0d b=%b c=%b want 23 1 0",
                     dif.count, dif.borrow_out, dif.carry_out);
        end
        dif.inc_in = 1;
        dif.dec_in = 1;
        step();
        dif.inc_in = 0;
        dif.dec_in = 0;
        vectors++;
        if (dif.count !== 5'd23 || dif.borrow_out !== 1'b0 ||
            dif.carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL chain_both: cnt=%0d b=%b c=%b want 23 0 0",
                     dif.count, dif.borrow_out, dif.carry_out);
        end
    endtask

    task automatic test_load();
        dif.load = 1;
        dif.load_val = 5'd30;
        step();
        vectors++;
        if (dif.count !== 5'd0 || dif.carry_out !== 1'b0 ||
            dif.borrow_out !== 1'b0) begin
            miscompares++;
            $display("FAIL load_oor: cnt=%0d c=%b b=%b want 0 0 0",
                     dif.count, dif.carry_out, dif.borrow_out);
        end
        dif.load_val = 5'd13;
        dif.enUP = 1;
        dif.formato_hora = 1;
        step();
        dif.load = 0;
        dif.enUP = 0;
        vectors++;
        if (dif.count !== 5'd13 || dif.digit1 !== 4'd0 ||
            dif.digit0 !== 4'd1 || dif.AM_PM !== 1'b1) begin
            miscompares++;
            $display("FAIL load_13: cnt=%0d d=%0d%0d pm=%b want 13 01 1",
                     dif.count, dif.digit1, dif.digit0, dif.AM_PM);
        end
        step();
        vectors++;
        if (dif.count !== 5'(m_count) || dif.count !== 5'd13) begin
            miscompares++;
            $display("FAIL load_hold: cnt=%0d want 13", dif.count);
        end
    endtask

    task automatic test_ignore();
        logic [N-1:0] start;
        start = dif.count;
        dif.enUP = 1;
        dif.enDOWN = 1;
        repeat (10 * (DIV + 1)) step();
        vectors++;
        if (dif.count !== start || dif.count !== 5'(m_count)) begin
            miscompares++;
            $display("FAIL ignore_both: cnt=%0d want %0d", dif.count, start);
        end
        dif.enUP = 0;
        dif.enDOWN = 0;
        step();
        dif.en_count = 4'd2;
        dif.enUP = 1;
        repeat (10 * (DIV + 1)) step();
        vectors++;
        if (dif.count !== start || dif.count !== 5'(m_count)) begin
            miscompares++;
            $display("FAIL ignore_unsel: cnt=%0d want %0d", dif.count, start);
        end
        dif.enUP = 0;
        dif.en_count = 4'(FID);
        step();
    endtask

    task automatic test_random();
        repeat (800) begin
            dif.en_count = ($urandom_range(0, 3) != 0) ? 4'(FID)
                                                       : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) dif.enUP = ~dif.enUP;
            if ($urandom_range(0, 11) == 0) dif.enDOWN = ~dif.enDOWN;
            dif.inc_in = ($urandom_range(0, 3) == 0);
            dif.dec_in = ($urandom_range(0, 4) == 0);
            dif.load = ($urandom_range(0, 24) == 0);
            dif.load_val = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) dif.formato_hora = ~dif.formato_hora;
            step();
            exp_dec(m_count, dif.formato_hora, e1, e0, ep);
            vectors++;
            if (dif.count !== 5'(m_count) || dif.carry_out !== m_carry ||
                dif.borrow_out !== m_borrow || dif.digit1 !== e1 ||
                dif.digit0 !== e0 || dif.AM_PM !== ep) begin
                miscompares++;
                $display("FAIL random: cnt=%0d c=%b b=%b d=%0d%0d pm=%b want %0d %b %b %0d%0d %b",
                         dif.count, dif.carry_out, dif.borrow_out,
                         dif.digit1, dif.digit0, dif.AM_PM,
                         m_count, m_carry, m_borrow, e1, e0, ep);
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 0;
        dif.formato_hora = 0;
        idle_inputs();
        test_reset();
        test_edit_wrap();
        test_hold_repeat();
        test_chain();
        test_load();
        test_ignore();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
